motion_magnitude_seq: RTL and testbench

//  Sequential, parametrised engine for the magnitude of a PS/2 mouse movement vector: sqrt(x^2+y^2) of pre-scaled deltas.

---
 rtl/ps2_mouse_pkg.sv | 29 ++
 rtl/isqrt_iter.sv | 63 ++++++
 rtl/motion_magnitude_seq.sv | 82 ++++++++
 tb/tb_motion_magnitude_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and helpers for the PS/2 mouse datapath: FSM states, derived
// widths for the magnitude engine, and delta magnitude with overflow handling.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {IDLE, SUM, ROOT, DONE} mm_state_e;

  function automatic int mw(int dw, int shift);
    return dw - shift;
  endfunction

  function automatic int sw(int dw, int shift);
    return 2 * mw(dw, shift) + 1;
  endfunction

  function automatic int rw(int dw, int shift);
    return mw(dw, shift) + 1;
  endfunction

  // |v| for a dw-bit two's complement value held zero-extended in v; the most
  // negative code yields 2^(dw-1), and the PS/2 overflow bit forces that value.
  function automatic logic [31:0] abs_ovf(logic [31:0] v, int dw, logic ovf);
    logic [31:0] full;
    full = 32'd1 << (dw - 1);
    if (ovf) return full;
    if ((v & full) != 32'd0) return (full << 1) - v;
    return v;
  endfunction

endpackage

// File: rtl/isqrt_iter.sv
// Restoring digit-by-digit integer square root, one result bit per cycle,
// MSB first. Radicand must be held stable by the caller while busy.
module isqrt_iter
  import ps2_mouse_pkg::*;
#(
  parameter int SW = 11,
  parameter int RW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] rad,
  output logic [RW-1:0] root,
  output logic [RW:0]   rem,
  output logic          done
);
  localparam int XW = 2 * RW;
  localparam int CW = $clog2(RW);

  logic [XW-1:0] radx;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [1:0]    pair;
  logic [RW+2:0] t, trial;

  assign radx  = XW'(rad);
  assign pair  = 2'(radx >> {cnt, 1'b0});
  assign t     = {rem, pair};
  assign trial = (RW+3)'({root, 2'b01});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      root <= '0;
      rem  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        root <= '0;
        rem  <= '0;
        cnt  <= CW'(RW - 1);
        busy <= 1'b1;
      end else if (busy) begin
        if (t >= trial) begin
          rem  <= (RW+1)'(t - trial);
          root <= {root[RW-2:0], 1'b1};
        end else begin
          rem  <= (RW+1)'(t);
          root <= {root[RW-2:0], 1'b0};
        end
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/motion_magnitude_seq.sv
// Sequential magnitude of a PS/2 movement vector: handshake FSM, abs/scale/
// square stage, iterative root and optional round-to-nearest.
module motion_magnitude_seq
  import ps2_mouse_pkg::*;
#(
  parameter  int DW    = 9,
  parameter  int SHIFT = 4,
  parameter  int ROUND = 0,
  localparam int MW    = mw(DW, SHIFT),
  localparam int SW    = sw(DW, SHIFT),
  localparam int RW    = rw(DW, SHIFT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_axis,
  input  logic [DW-1:0] y_axis,
  input  logic          x_ovf,
  input  logic          y_ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_mag
);
  mm_state_e     state_q, state_d;
  logic [MW-1:0] mx, my, mx_n, my_n;
  logic [SW-1:0] s_reg, sum_n;
  logic [RW-1:0] root_q, mag_n;
  logic [RW:0]   rem_q;
  logic          sq_done;

  assign mx_n  = MW'(abs_ovf(32'(x_axis), DW, x_ovf) >> SHIFT);
  assign my_n  = MW'(abs_ovf(32'(y_axis), DW, y_ovf) >> SHIFT);
  assign sum_n = SW'(mx) * SW'(mx) + SW'(my) * SW'(my);

  // rem > root means s >= (root+0.5)^2, i.e. the true root rounds up.
  assign mag_n = (ROUND != 0 && rem_q > (RW+1)'(root_q) && root_q != '1)
                 ? RW'(root_q + 1'b1) : root_q;

  isqrt_iter #(.SW(SW), .RW(RW)) u_isqrt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_q == SUM),
    .rad   (s_reg),
    .root  (root_q),
    .rem   (rem_q),
    .done  (sq_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mx      <= '0;
      my      <= '0;
      s_reg   <= '0;
      out_mag <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        mx <= mx_n;
        my <= my_n;
      end
      if (state_q == SUM) s_reg <= sum_n;
      if (state_q == ROOT && sq_done) out_mag <= mag_n;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SUM;
      SUM:                    state_d = ROOT;
      ROOT:    if (sq_done)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_motion_magnitude_seq.sv
// Bench for motion_magnitude_seq: directed table, backpressure and reset
// sequences, then a random sweep against a plain-arithmetic sqrt model.
module tb_motion_magnitude_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // group A: DW=9 SHIFT=4, ROUND 0 and 1 share inputs
  logic       a_iv = 0, a_or = 0, a_xo = 0, a_yo = 0;
  logic [8:0] a_x = '0, a_y = '0;
  logic       a_ir0, a_ov0, a_ir1, a_ov1;
  logic [5:0] a_m0, a_m1;
  // group C: DW=12 SHIFT=2, ROUND 0 and 1 share inputs
  logic        c_iv = 0, c_or = 0, c_xo = 0, c_yo = 0;
  logic [11:0] c_x = '0, c_y = '0;
  logic        c_ir0, c_ov0, c_ir1, c_ov1;
  logic [10:0] c_m0, c_m1;

  motion_magnitude_seq #(.DW(9), .SHIFT(4), .ROUND(0)) dut_a0 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir0), .x_axis(a_x), .y_axis(a_y),
    .x_ovf(a_xo), .y_ovf(a_yo), .out_valid(a_ov0), .out_ready(a_or), .out_mag(a_m0));
  motion_magnitude_seq #(.DW(9), .SHIFT(4), .ROUND(1)) dut_a1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir1), .x_axis(a_x), .y_axis(a_y),
    .x_ovf(a_xo), .y_ovf(a_yo), .out_valid(a_ov1), .out_ready(a_or), .out_mag(a_m1));
  motion_magnitude_seq #(.DW(12), .SHIFT(2), .ROUND(0)) dut_c0 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir0), .x_axis(c_x), .y_axis(c_y),
    .x_ovf(c_xo), .y_ovf(c_yo), .out_valid(c_ov0), .out_ready(c_or), .out_mag(c_m0));
  motion_magnitude_seq #(.DW(12), .SHIFT(2), .ROUND(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir1), .x_axis(c_x), .y_axis(c_y),
    .x_ovf(c_xo), .y_ovf(c_yo), .out_valid(c_ov1), .out_ready(c_or), .out_mag(c_m1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // floor(sqrt) by search; rounding decided by 4s vs (2q+1)^2
  function automatic int ref_mag(int dw, int sh, int rnd, int x, int y, bit xo, bit yo);
    longint half, ax, ay, s, q;
    half = longint'(1) << (dw - 1);
    ax = xo ? half : ((x >= half) ? 2 * half - x : x);
    ay = yo ? half : ((y >= half) ? 2 * half - y : y);
    ax = ax >> sh;
    ay = ay >> sh;
    s = ax * ax + ay * ay;
    q = 0;
    while ((q + 1) * (q + 1) <= s) q++;
    if (rnd != 0 && 4 * s > (2 * q + 1) * (2 * q + 1)) q++;
    return int'(q);
  endfunction

  function automatic bit ready_of(int g);
    return (g == 0) ? (a_ir0 & a_ir1) : (c_ir0 & c_ir1);
  endfunction

  function automatic bit valid_of(int g);
    return (g == 0) ? (a_ov0 & a_ov1) : (c_ov0 & c_ov1);
  endfunction

  task automatic drive(input int g, input int x, input int y, input bit xo, input bit yo, input bit v);
    if (g == 0) begin
      a_x = 9'(x); a_y = 9'(y); a_xo = xo; a_yo = yo; a_iv = v;
    end else begin
      c_x = 12'(x); c_y = 12'(y); c_xo = xo; c_yo = yo; c_iv = v;
    end
  endtask

  // one full transaction; samples are taken 1 time unit after the rising edge
  task automatic do_op(input int g, input int x, input int y, input bit xo, input bit yo,
                       output int m0, output int m1, output int lat);
    int n;
    n = 0;
    while (!ready_of(g) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ready_of(g)) chk("ready_timeout", 0, 1);
    drive(g, x, y, xo, yo, 1'b1);
    @(posedge clk); #1;
    drive(g, x, y, xo, yo, 1'b0);
    lat = 0;
    while (!valid_of(g) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!valid_of(g)) chk("valid_timeout", 0, 1);
    m0 = (g == 0) ? int'(a_m0) : int'(c_m0);
    m1 = (g == 0) ? int'(a_m1) : int'(c_m1);
    if (g == 0) a_or = 1'b1; else c_or = 1'b1;
    @(posedge clk); #1;
    a_or = 1'b0; c_or = 1'b0;
  endtask

  typedef struct {
    int g; int x; int y; bit xo; bit yo; int e0; int e1;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int m0, m1, lat, dw, sh, x, y, g;
    bit xo, yo, seen;

    tbl[0] = '{0, 'h030, 'h1C0, 0, 0, 5, 5};
    tbl[1] = '{0, 'h100, 'h000, 0, 0, 16, 16};
    tbl[2] = '{0, 'h005, 'h000, 1, 0, 16, 16};
    tbl[3] = '{0, 'h040, 'h040, 0, 0, 5, 6};
    tbl[4] = '{0, 'h100, 'h100, 0, 0, 22, 23};
    tbl[5] = '{0, 'h000, 'h000, 0, 0, 0, 0};
    tbl[6] = '{0, 'h0FF, 'h1FF, 0, 0, 15, 15};
    tbl[7] = '{1, 'h800, 'h000, 0, 0, 512, 512};
    tbl[8] = '{1, 'h800, 'h800, 0, 0, 724, 724};
    tbl[9] = '{1, 'h7FF, 'h123, 0, 1, 723, 723};

    // reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", a_ir0, 1);
    chk("rst_out_valid", a_ov0, 0);
    chk("rst_out_mag", a_m0, 0);

    // directed table; latency is RW+2 edges after the accepting edge
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].g, tbl[i].x, tbl[i].y, tbl[i].xo, tbl[i].yo, m0, m1, lat);
      chk($sformatf("tbl%0d_r0", i), m0, tbl[i].e0);
      chk($sformatf("tbl%0d_r1", i), m1, tbl[i].e1);
      chk($sformatf("tbl%0d_lat", i), lat, (tbl[i].g == 0) ? 8 : 13);
    end

    // backpressure: result held for 20 cycles with out_ready low
    drive(0, 'h030, 'h1C0, 0, 0, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1'b0);
    lat = 0;
    while (!a_ov0 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp_valid_rise", a_ov0, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", a_ov0, 1);
      chk("bp_mag_hold", a_m0, 5);
      chk("bp_in_ready_low", a_ir0, 0);
    end
    a_or = 1'b1;
    @(posedge clk); #1;
    a_or = 1'b0;
    chk("bp_valid_drop", a_ov0, 0);
    chk("bp_in_ready_back", a_ir0, 1);
    chk("bp_mag_retained", a_m0, 5);

    // reset during ROOT abandons the operation
    drive(0, 'h100, 'h100, 0, 0, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", a_ov0, 0);
    chk("midrst_in_ready", a_ir0, 1);
    chk("midrst_out_mag", a_m0, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (a_ov0 || a_ov1) seen = 1;
    end
    chk("midrst_no_stale", seen, 0);

    // random sweep over both widths, both rounding modes
    for (int i = 0; i < 160; i++) begin
      g  = i % 2;
      dw = (g == 0) ? 9 : 12;
      sh = (g == 0) ? 4 : 2;
      x  = int'($urandom_range(0, (1 << dw) - 1));
      y  = int'($urandom_range(0, (1 << dw) - 1));
      xo = ($urandom_range(0, 7) == 0);
      yo = ($urandom_range(0, 7) == 0);
      do_op(g, x, y, xo, yo, m0, m1, lat);
      chk($sformatf("rnd%0d_dw%0d_r0 x=%0h y=%0h", i, dw, x, y), m0, ref_mag(dw, sh, 0, x, y, xo, yo));
      chk($sformatf("rnd%0d_dw%0d_r1 x=%0h y=%0h", i, dw, x, y), m1, ref_mag(dw, sh, 1, x, y, xo, yo));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
